// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Initiator between the MEM stage and the 1024x32 word-addressed data RAM.
//   It turns byte-addressed load/store requests (byte/half/word, signed or
//   unsigned) into RAM read/write strobes. The RAM has no byte enables, so a
//   sub-word store is done as read-modify-write. Only one request is in
//   flight at a time.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_*         request handshake and fields, sampled only on the accept edge
//   resp_valid    one-cycle completion pulse; resp_err is valid with it
//   resp_rdata    extended load result, held until the next load completes
//   ram_addr/din  RAM word address and write data
//   ram_str/ld    RAM write and read strobes (never high together)
//   ram_dout      RAM read data, valid the cycle after ram_ld is sampled
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                sgn_q, sgn_d;
  logic                err_q, err_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_din_q, ram_din_d;
  logic                ram_str_q, ram_str_d;
  logic                ram_ld_q, ram_ld_d;

  logic                accept_s;
  logic                bad_req_s;

  // Address bits above the RAM window alias and are intentionally dropped.
  logic                unused_addr_s;
  assign unused_addr_s = ^req_addr[31:ADDR_W+2];

  // Reserved size or a misaligned half/word access is rejected without RAM traffic.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane(s) out of a RAM word and sign/zero extend.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-justified store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = w;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   m[7:0]   = d[7:0];
          2'b01:   m[15:8]  = d[7:0];
          2'b10:   m[23:16] = d[7:0];
          default: m[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          m[31:16] = d[15:0];
        end else begin
          m[15:0] = d[15:0];
        end
      end
      default: m = d;
    endcase
    return m;
  endfunction

  assign accept_s  = req_valid && (state_q == S_IDLE);
  assign bad_req_s = misaligned(req_size, req_addr[1:0]);

  // Next state, request latches, and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    err_d        = err_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          we_d    = req_we;
          sgn_d   = req_signed;
          size_d  = req_size;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          err_d   = bad_req_s;
          if (bad_req_s) begin
            state_d = S_RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: state_d = S_RDW;
      S_RDW: begin
        if (we_q) begin
          wdata_d = merge(ram_dout, wdata_q, size_q, addr_q[1:0]);
          state_d = S_WR;
        end else begin
          resp_rdata_d = extract(ram_dout, size_q, addr_q[1:0], sgn_q);
          state_d      = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they stay Moore-aligned.
    req_ready_d  = (state_d == S_IDLE);
    ram_ld_d     = (state_d == S_RD);
    ram_str_d    = (state_d == S_WR);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = (state_d == S_RESP) && err_d;
    if ((state_d == S_RD) || (state_d == S_WR)) begin
      ram_addr_d = addr_d[ADDR_W+1:2];
    end else begin
      ram_addr_d = ram_addr_q;
    end
    if (state_d == S_WR) begin
      ram_din_d = wdata_d;
    end else begin
      ram_din_d = ram_din_q;
    end
  end

  // State, request latches and output registers; reset drops any access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      ram_addr_q   <= '0;
      ram_din_q    <= 32'h0000_0000;
      ram_str_q    <= 1'b0;
      ram_ld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      err_q        <= err_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_str_q    <= ram_str_d;
      ram_ld_q     <= ram_ld_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_str    = ram_str_q;
  assign ram_ld     = ram_ld_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a behavioural 1024x32 RAM.
//   Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_str;
  logic        ram_ld;
  logic [31:0] ram_dout;

  int checks   = 0;
  int failures = 0;

  int          str_cnt, ld_cnt, both_cnt;
  logic [9:0]  str_addr;
  logic [31:0] str_din;
  int          lat;
  logic        got_err;
  logic [31:0] got_rdata;

  logic [31:0] mem [1024];

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_str(ram_str), .ram_ld(ram_ld),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_str) mem[ram_addr] <= ram_din;
    if (ram_ld)  ram_dout <= mem[ram_addr];
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (ram_str) begin
      str_cnt  <= str_cnt + 1;
      str_addr <= ram_addr;
      str_din  <= ram_din;
    end
    if (ram_ld) ld_cnt <= ld_cnt + 1;
    if (ram_ld && ram_str) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Issue one request; lat = posedges from the accept edge until resp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    int w;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    str_cnt = 0; ld_cnt = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (hold) scramble(); else req_valid = 1'b0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (hold) scramble();
    end
    got_err   = resp_err;
    got_rdata = resp_rdata;
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
    ram_dout = 32'h0000_0000;
    str_cnt = 0; ld_cnt = 0; both_cnt = 0;
    str_addr = 10'd0; str_din = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid_err_str_ld", {28'd0, resp_valid, resp_err, ram_str, ram_ld}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr_din", {22'd0, ram_addr} | ram_din, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: word store
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    check("t1_lat", lat, 32'd2);
    check("t1_err", {31'd0, got_err}, 32'd0);
    check("t1_str_cnt", str_cnt, 32'd1);
    check("t1_ld_cnt", ld_cnt, 32'd0);
    check("t1_str_addr", {22'd0, str_addr}, 32'd4);
    check("t1_str_din", str_din, 32'hDEADBEEF);

    // 2: sub-word loads
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    check("t2_sb_lat", lat, 32'd3);
    check("t2_sb_data", got_rdata, 32'hFFFFFFDE);
    check("t2_sb_ld_cnt", ld_cnt, 32'd1);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    check("t2_ub_data", got_rdata, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    check("t2_sh_data", got_rdata, 32'hFFFFDEAD);
    check("t2_sh_err", {31'd0, got_err}, 32'd0);
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t2_ub0_data", got_rdata, 32'h000000EF);

    // 3: byte store via read-modify-write
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55, 1'b0);
    check("t3_lat", lat, 32'd4);
    check("t3_ld_cnt", ld_cnt, 32'd1);
    check("t3_str_cnt", str_cnt, 32'd1);
    check("t3_str_din", str_din, 32'hDEAD55EF);
    check("t3_rdata_kept", got_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t3_wl_data", got_rdata, 32'hDEAD55EF);
    // Half store into upper lane
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 1'b0);
    check("t3_hs_din", str_din, 32'hCAFE55EF);
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000DEAD, 1'b0);

    // 4: errors
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0);
    check("t4_half_lat", lat, 32'd1);
    check("t4_half_err", {31'd0, got_err}, 32'd1);
    check("t4_half_rdata", got_rdata, 32'hDEAD55EF);
    check("t4_half_ld", ld_cnt, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h11111111, 1'b0);
    check("t4_word_err", {31'd0, got_err}, 32'd1);
    check("t4_word_str", str_cnt, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t4_rsv_err", {31'd0, got_err}, 32'd1);
    check("t4_rsv_lat", lat, 32'd1);
    check("t4_rsv_ldstr", ld_cnt + str_cnt, 32'd0);

    // 5: reset during RDW of a byte store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h000000AA; req_valid = 1'b1;
    str_cnt = 0;
    @(posedge clk);          // accept -> RD
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);          // -> RDW
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_str_ld", {30'd0, ram_str, ram_ld}, 32'd0);
    check("t5_valid_ready", {30'd0, resp_valid, req_ready}, 32'd1);
    check("t5_rdata", resp_rdata, 32'h0);
    check("t5_addr_din", {22'd0, ram_addr} | ram_din, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_str", str_cnt, 32'd0);
    check("t5_ram_word", mem[4], 32'hDEAD55EF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t5_after_lat", lat, 32'd3);
    check("t5_after_data", got_rdata, 32'hDEAD55EF);

    // 6: fields change while busy; address aliasing
    do_req(1'b1, 2'b10, 1'b0, 32'h1010, 32'h12345678, 1'b1);
    check("t6_str_addr", {22'd0, str_addr}, 32'd4);
    check("t6_str_din", str_din, 32'h12345678);
    check("t6_str_cnt", str_cnt, 32'd1);
    do_req(1'b0, 2'b00, 1'b0, 32'h1012, 32'h0, 1'b1);
    check("t6_ub_data", got_rdata, 32'h00000034);
    check("t6_ub_lat", lat, 32'd3);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
    check("t6_sh_data", got_rdata, 32'h00001234);

    repeat (2) @(negedge clk);
    check("never_both_strobes", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
